// File: rtl/muldiv_unit_pkg.sv
/*------------------------------------------------------------------------
 * muldiv_unit_pkg -- FSM states, iteration count and opcode decode.
 * Rev 1.0
 *----------------------------------------------------------------------*/
`include "alu_control_def.v"
`default_nettype none

package muldiv_unit_pkg;

  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // sel_alt picks the high product half for multiplies, the remainder for divides
  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic sel_alt;
  } op_info_t;

  function automatic logic is_muldiv(input logic [4:0] code);
    case (code)
      `ALUCTRL_MUL, `ALUCTRL_MULH, `ALUCTRL_MULHSU, `ALUCTRL_MULHU,
      `ALUCTRL_DIV, `ALUCTRL_DIVU, `ALUCTRL_REM,    `ALUCTRL_REMU: is_muldiv = 1'b1;
      default:                                                      is_muldiv = 1'b0;
    endcase
  endfunction

  function automatic op_info_t decode_op(input logic [4:0] code);
    op_info_t info;
    info = '0;
    case (code)
      `ALUCTRL_MULH:   info = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, sel_alt: 1'b1};
      `ALUCTRL_MULHSU: info = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b0, sel_alt: 1'b1};
      `ALUCTRL_MULHU:  info = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, sel_alt: 1'b1};
      `ALUCTRL_DIV:    info = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_alt: 1'b0};
      `ALUCTRL_DIVU:   info = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_alt: 1'b0};
      `ALUCTRL_REM:    info = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_alt: 1'b1};
      `ALUCTRL_REMU:   info = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_alt: 1'b1};
      default:         info = '0;
    endcase
    return info;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_control_def.v
/*------------------------------------------------------------------------
 * alu_control_def -- shared ALUCtrl operation codes from the control unit.
 * Rev 1.0
 *----------------------------------------------------------------------*/
`default_nettype none
`ifndef ALU_CONTROL_DEF_V
`define ALU_CONTROL_DEF_V

`define ALUCTRL_ADD    5'b00000
`define ALUCTRL_SUB    5'b00001
`define ALUCTRL_AND    5'b00010
`define ALUCTRL_OR     5'b00011
`define ALUCTRL_XOR    5'b00100
`define ALUCTRL_SLL    5'b00101
`define ALUCTRL_SRL    5'b00110
`define ALUCTRL_SRA    5'b00111
`define ALUCTRL_SLT    5'b01000
`define ALUCTRL_SLTU   5'b01001
`define ALUCTRL_MUL    5'b10000
`define ALUCTRL_MULH   5'b10001
`define ALUCTRL_MULHSU 5'b10010
`define ALUCTRL_MULHU  5'b10011
`define ALUCTRL_DIV    5'b10100
`define ALUCTRL_DIVU   5'b10101
`define ALUCTRL_REM    5'b10110
`define ALUCTRL_REMU   5'b10111

`endif
`default_nettype wire

// File: rtl/muldiv_step.sv
/*------------------------------------------------------------------------
 * muldiv_step -- one shift-add multiply or restoring-divide iteration.
 * Rev 1.0
 *----------------------------------------------------------------------*/
`default_nettype none

module muldiv_step #(
  parameter int BITS = 32
) (
  input  logic            is_div_i,
  input  logic [BITS-1:0] hi_i,
  input  logic [BITS-1:0] lo_i,
  input  logic [BITS-1:0] operand_i,
  output logic [BITS-1:0] hi_o,
  output logic [BITS-1:0] lo_o
);

  logic [BITS:0] add_sum;
  logic [BITS:0] shifted;

  // Multiply: {hi,lo} shifts right, lo holds the unconsumed multiplier bits.
  // Divide: {hi,lo} shifts left, hi is the partial remainder, quotient bits enter lo.
  always_comb begin
    add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
    shifted = {hi_i, lo_i[BITS-1]};
    hi_o    = add_sum[BITS:1];
    lo_o    = {add_sum[0], lo_i[BITS-1:1]};
    if (is_div_i) begin
      if (shifted >= {1'b0, operand_i}) begin
        hi_o = shifted[BITS-1:0] - operand_i;
        lo_o = {lo_i[BITS-2:0], 1'b1};
      end else begin
        hi_o = shifted[BITS-1:0];
        lo_o = {lo_i[BITS-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
/*------------------------------------------------------------------------
 * muldiv_unit -- iterative 32-cycle RV32M multiply/divide with pipeline stall.
 * Rev 1.0
 *----------------------------------------------------------------------*/
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [4:0]      ALUCtrl,
  input  logic            flush,
  input  logic [BITS-1:0] op_a,
  input  logic [BITS-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [BITS-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        ctrl_q;
  logic              a_sign_q;
  logic [BITS-1:0]   op_b_q;
  logic [BITS-1:0]   hi_q;
  logic [BITS-1:0]   lo_q;
  logic              done_q;
  logic [BITS-1:0]   result_q;

  op_info_t          info;
  logic              start;
  logic              a_neg;
  logic              b_neg;
  logic [BITS-1:0]   mag_b;
  logic [BITS-1:0]   step_lo_in;
  logic [BITS-1:0]   step_hi;
  logic [BITS-1:0]   step_lo;
  logic [2*BITS-1:0] prod_d;
  logic [BITS-1:0]   quo_d;
  logic [BITS-1:0]   rem_d;
  logic [BITS-1:0]   result_d;

  assign start  = valid && is_muldiv(ALUCtrl) && !flush;
  assign stall  = !rst && (((state_q == S_IDLE) && start) || (state_q == S_BUSY));
  assign done   = done_q;
  assign result = result_q;

  assign info  = decode_op(ctrl_q);
  assign a_neg = info.a_signed && a_sign_q;
  assign b_neg = info.b_signed && op_b_q[BITS-1];
  assign mag_b = b_neg ? -op_b_q : op_b_q;

  // lo_q holds the raw op_a until the first step, which consumes its magnitude
  assign step_lo_in = ((cnt_q == '0) && a_neg) ? -lo_q : lo_q;

  muldiv_step #(
    .BITS (BITS)
  ) u_step (
    .is_div_i  (info.is_div),
    .hi_i      (hi_q),
    .lo_i      (step_lo_in),
    .operand_i (mag_b),
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  // Divide by zero keeps the all-ones quotient regardless of dividend sign
  always_comb begin
    prod_d = {step_hi, step_lo};
    if (a_neg ^ b_neg) prod_d = -prod_d;
    quo_d = step_lo;
    if ((a_neg ^ b_neg) && (op_b_q != '0)) quo_d = -step_lo;
    rem_d = a_neg ? -step_hi : step_hi;
    if (info.is_div) result_d = info.sel_alt ? rem_d : quo_d;
    else             result_d = info.sel_alt ? prod_d[2*BITS-1:BITS] : prod_d[BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ctrl_q   <= '0;
      a_sign_q <= 1'b0;
      op_b_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_BUSY;
            cnt_q    <= '0;
            ctrl_q   <= ALUCtrl;
            a_sign_q <= op_a[BITS-1];
            op_b_q   <= op_b;
            hi_q     <= '0;
            lo_q     <= op_a;
          end
        end
        S_BUSY: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= result_d;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
